// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size encodings, FSM states,
// the registered request record and small lane/split helpers.
// Build option: define LSU_MISALIGN_EN to execute split (misaligned) accesses
// as two memory beats; without it such accesses are answered with an error.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC0 = 2'b01,
        ACC1 = 2'b10,
        RESP = 2'b11
    } state_e;

`ifdef LSU_MISALIGN_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    // Request fields held for the whole access; only the low 15 address bits matter.
    typedef struct packed {
        logic        we;
        size_e       size;
        logic        uns;
        logic [14:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Byte-lane mask of an access placed at offset 0.
    function automatic logic [3:0] size_mask(input size_e size);
        case (size)
            SIZE_BYTE: return 4'b0001;
            SIZE_HALF: return 4'b0011;
            SIZE_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    // True when the lane mask spills into the next word (upper lane nibble non-zero).
    function automatic logic is_split(input size_e size, input logic [1:0] offset);
        return ((size == SIZE_HALF) && (offset == 2'd3)) ||
               ((size == SIZE_WORD) && (offset != 2'd0));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU-side request/response bundle of the load/store unit.
// master = CPU issuing accesses, slave = load/store unit serving them.
interface lsu_if;

    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational alignment datapath: byte-lane selects per beat, store data
// shifted into memory lanes, and load data extracted and size-extended.
// With LSU_MISALIGN_EN the second (beat1) lanes/data paths are present.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] ld_beat0,
`ifdef LSU_MISALIGN_EN
    input  logic [31:0] ld_beat1,
    output logic [3:0]  sel_beat1,
    output logic [31:0] st_beat1,
`endif
    output logic [3:0]  sel_beat0,
    output logic [31:0] st_beat0,
    output logic [31:0] ld_data
);

    logic [4:0]  shamt;
    logic [31:0] ld_word;

    assign shamt = {offset, 3'b000};

`ifdef LSU_MISALIGN_EN
    logic [7:0]  lanes;
    logic [63:0] st_wide;
    logic [63:0] ld_cat;

    assign lanes     = {4'b0000, size_mask(size)} << offset;
    assign sel_beat0 = lanes[3:0];
    assign sel_beat1 = lanes[7:4];

    assign st_wide   = {32'h0000_0000, wdata} << shamt;
    assign st_beat0  = st_wide[31:0];
    assign st_beat1  = st_wide[63:32];

    assign ld_cat    = {ld_beat1, ld_beat0};
    assign ld_word   = ld_cat[shamt +: 32];
`else
    assign sel_beat0 = size_mask(size) << offset;
    assign st_beat0  = wdata << shamt;
    assign ld_word   = ld_beat0 >> shamt;
`endif

    // Truncate the shifted load word to the access size and extend it.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        ld_data = 32'h0000_0000;
        case (size)
            SIZE_BYTE: ld_data = uns ? {24'h00_0000, ld_word[7:0]}
                                     : {{24{ld_word[7]}}, ld_word[7:0]};
            SIZE_HALF: ld_data = uns ? {16'h0000, ld_word[15:0]}
                                     : {{16{ld_word[15]}}, ld_word[15:0]};
            SIZE_WORD: ld_data = ld_word;
            default:   ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU access at a time, issues one or two
// byte-lane-masked memory beats, and returns a one-cycle response.
// Build option: LSU_MISALIGN_EN enables two-beat split accesses (ACC1 state).
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    lsu_if.slave        cpu,
    output logic        mem_write_o,
    output logic [3:0]  mem_b_sel_o,
    output logic [12:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i
);

    state_e      state_q, state_d;
    req_t        req_q;
    logic        err_q;
    logic [31:0] beat0_q;
    logic        accept;
    logic        new_err;
    logic [3:0]  sel_beat0;
    logic [31:0] st_beat0;
    logic [31:0] ld_data;
    logic        unused_addr_hi;

`ifdef LSU_MISALIGN_EN
    logic [31:0] beat1_q;
    logic [3:0]  sel_beat1;
    logic [31:0] st_beat1;
`endif

    // Address bits above the 32 KiB window are ignored by design.
    assign unused_addr_hi = &{1'b0, cpu.req_addr_i[31:15]};

    assign accept  = cpu.req_valid_i && (state_q == IDLE) && !rst_i;
    assign new_err = (size_e'(cpu.req_size_i) == SIZE_RSVD) ||
                     (!MISALIGN_EN && is_split(size_e'(cpu.req_size_i), cpu.req_addr_i[1:0]));

    lsu_align u_align (
        .size      (req_q.size),
        .offset    (req_q.addr[1:0]),
        .uns       (req_q.uns),
        .wdata     (req_q.wdata),
        .ld_beat0  (beat0_q),
`ifdef LSU_MISALIGN_EN
        .ld_beat1  (beat1_q),
        .sel_beat1 (sel_beat1),
        .st_beat1  (st_beat1),
`endif
        .sel_beat0 (sel_beat0),
        .st_beat0  (st_beat0),
        .ld_data   (ld_data)
    );

    // FSM state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture on acceptance and load-beat capture at the end of each beat.
    always_ff @(posedge clk_i) begin
        // NOTE: datapath registers are not reset; they are only observed once the FSM has loaded them.
        if (accept) begin
            req_q.we    <= cpu.req_we_i;
            req_q.size  <= size_e'(cpu.req_size_i);
            req_q.uns   <= cpu.req_unsigned_i;
            req_q.addr  <= cpu.req_addr_i[14:0];
            req_q.wdata <= cpu.req_wdata_i;
            err_q       <= new_err;
        end
        if (state_q == ACC0) begin
            beat0_q <= mem_data_i;
        end
`ifdef LSU_MISALIGN_EN
        if (state_q == ACC1) begin
            beat1_q <= mem_data_i;
        end
`endif
    end

    // Next-state logic and Moore outputs; reset forces every output low.
    always_comb begin
        state_d         = state_q;
        cpu.req_ready_o = 1'b0;
        cpu.rsp_valid_o = 1'b0;
        cpu.rsp_rdata_o = 32'h0000_0000;
        cpu.rsp_err_o   = 1'b0;
        mem_write_o     = 1'b0;
        mem_b_sel_o     = 4'b0000;
        mem_addr_o      = 13'h0000;
        mem_data_o      = 32'h0000_0000;

        case (state_q)
            IDLE: begin
                cpu.req_ready_o = 1'b1;
                if (accept) begin
                    state_d = new_err ? RESP : ACC0;
                end
            end
            ACC0: begin
                mem_write_o = req_q.we;
                mem_b_sel_o = sel_beat0;
                mem_addr_o  = req_q.addr[14:2];
                mem_data_o  = req_q.we ? st_beat0 : 32'h0000_0000;
`ifdef LSU_MISALIGN_EN
                state_d     = (sel_beat1 != 4'b0000) ? ACC1 : RESP;
`else
                state_d     = RESP;
`endif
            end
`ifdef LSU_MISALIGN_EN
            ACC1: begin
                mem_write_o = req_q.we;
                mem_b_sel_o = sel_beat1;
                mem_addr_o  = req_q.addr[14:2] + 13'd1;
                mem_data_o  = req_q.we ? st_beat1 : 32'h0000_0000;
                state_d     = RESP;
            end
`endif
            RESP: begin
                cpu.rsp_valid_o = 1'b1;
                cpu.rsp_err_o   = err_q;
                cpu.rsp_rdata_o = (err_q || req_q.we) ? 32'h0000_0000 : ld_data;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst_i) begin
            cpu.req_ready_o = 1'b0;
            cpu.rsp_valid_o = 1'b0;
            cpu.rsp_rdata_o = 32'h0000_0000;
            cpu.rsp_err_o   = 1'b0;
            mem_write_o     = 1'b0;
            mem_b_sel_o     = 4'b0000;
            mem_addr_o      = 13'h0000;
            mem_data_o      = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed steps followed by random
// accesses checked against a byte-addressed reference memory model.
module tb_load_store_unit;

    logic        clk_i;
    logic        rst_i;
    logic        mem_write_o;
    logic [3:0]  mem_b_sel_o;
    logic [12:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    lsu_if bus ();

    load_store_unit dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu         (bus),
        .mem_write_o (mem_write_o),
        .mem_b_sel_o (mem_b_sel_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i)
    );

`ifdef LSU_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Simple word-organised memory on the bus side.
    logic [31:0] bus_mem [0:8191];
    bit          mem_init_done = 1'b0;

    // Reference model: flat byte-addressed 32 KiB space.
    logic [7:0]  ref_mem [0:32767];

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    always_comb begin
        mem_data_i = 32'h0000_0000;
        for (int b = 0; b < 4; b++) begin
            if (mem_b_sel_o[b]) mem_data_i[8*b +: 8] = bus_mem[mem_addr_o][8*b +: 8];
        end
    end

    always @(posedge clk_i) begin
        if (!mem_init_done) begin
            for (int w = 0; w < 8192; w++) bus_mem[w] <= init_word(w);
            mem_init_done <= 1'b1;
        end else if (mem_write_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_b_sel_o[b]) bus_mem[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
            end
        end
    end

    // Results captured by do_access.
    int          n_beats, n_valid, lat;
    logic [12:0] beat_addr [4];
    logic [3:0]  beat_sel  [4];
    logic [31:0] beat_data [4];
    logic        beat_we   [4];
    logic        got_err;
    logic [31:0] got_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---- reference model -------------------------------------------------
    function automatic int nbytes(input logic [1:0] size);
        case (size)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_split(input logic [1:0] size, input logic [31:0] addr);
        return (nbytes(size) != 0) && (int'(addr[1:0]) + nbytes(size) > 4);
    endfunction

    function automatic bit model_err(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'b11) || (model_split(size, addr) && !MIS_EN);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr);
        logic [31:0] v;
        logic [14:0] a;
        int          n;
        n = nbytes(size);
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            a = addr[14:0] + 15'(i);
            v = v | (32'(ref_mem[a]) << (8 * i));
        end
        if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        return v;
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata);
        logic [14:0] a;
        for (int i = 0; i < nbytes(size); i++) begin
            a = addr[14:0] + 15'(i);
            ref_mem[a] = wdata[8*i +: 8];
        end
    endtask

    // ---- bus driver/monitor ----------------------------------------------
    task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int waited = 0;
        n_beats   = 0;
        n_valid   = 0;
        lat       = 0;
        got_err   = 1'b0;
        got_rdata = 32'h0;
        @(negedge clk_i);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wdata;
        while (bus.req_ready_o !== 1'b1 && waited < 16) begin
            @(negedge clk_i);
            waited++;
        end
        if (waited >= 16) check("accept_timeout", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk_i);
        #1 bus.req_valid_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_i);
            if (mem_b_sel_o != 4'b0000 && n_beats < 4) begin
                beat_addr[n_beats] = mem_addr_o;
                beat_sel[n_beats]  = mem_b_sel_o;
                beat_data[n_beats] = mem_data_o;
                beat_we[n_beats]   = mem_write_o;
                n_beats++;
            end
            if (bus.rsp_valid_o === 1'b1) begin
                if (n_valid == 0) begin
                    lat       = k;
                    got_err   = bus.rsp_err_o;
                    got_rdata = bus.rsp_rdata_o;
                end
                n_valid++;
            end
        end
    endtask

    // One access checked end to end against the model.
    task automatic run_and_check(input string tag, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        bit          e_err;
        logic [31:0] e_rdata;
        int          e_lat, e_beats;
        e_err   = model_err(size, addr);
        e_rdata = (e_err || we) ? 32'h0 : model_load(size, uns, addr);
        e_lat   = e_err ? 1 : (model_split(size, addr) ? 3 : 2);
        e_beats = e_err ? 0 : (model_split(size, addr) ? 2 : 1);
        do_access(we, size, uns, addr, wdata);
        check({tag, "_pulses"}, 32'(n_valid), 32'd1);
        check({tag, "_err"},    32'(got_err), 32'(e_err));
        check({tag, "_rdata"},  got_rdata, e_rdata);
        check({tag, "_lat"},    32'(lat), 32'(e_lat));
        check({tag, "_beats"},  32'(n_beats), 32'(e_beats));
        if (we && !e_err) model_store(size, addr, wdata);
    endtask

    initial begin
        int quiet_valid, quiet_write;
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_size_i     = 2'b00;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 32'h0;
        bus.req_wdata_i    = 32'h0;
        rst_i              = 1'b1;
        for (int w = 0; w < 8192; w++) begin
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = init_word(w)[8*b +: 8];
        end

        // Reset state.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_rsp_err",   32'(bus.rsp_err_o),   32'd0);
        check("rst_rdata",     bus.rsp_rdata_o,      32'd0);
        check("rst_mem_write", 32'(mem_write_o),     32'd0);
        check("rst_mem_bsel",  32'(mem_b_sel_o),     32'd0);
        check("rst_mem_addr",  32'(mem_addr_o),      32'd0);
        check("rst_mem_data",  mem_data_o,           32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_ready_after", 32'(bus.req_ready_o), 32'd1);

        // Word store at 0x10.
        run_and_check("st_word", 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        check("st_word_addr",  32'(beat_addr[0]), 32'd4);
        check("st_word_bsel",  32'(beat_sel[0]),  32'hF);
        check("st_word_we",    32'(beat_we[0]),   32'd1);
        check("st_word_data",  beat_data[0],      32'hDEAD_BEEF);
        check("st_word_mem",   bus_mem[4],        32'hDEAD_BEEF);

        run_and_check("st_word5", 1'b1, 2'b10, 1'b0, 32'h0000_0014, 32'h1122_3344);

        // Byte loads at 0x13, signed and unsigned.
        run_and_check("ld_sbyte", 1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0);
        check("ld_sbyte_bsel",  32'(beat_sel[0]), 32'h8);
        check("ld_sbyte_value", got_rdata,        32'hFFFF_FFDE);
        run_and_check("ld_ubyte", 1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0);
        check("ld_ubyte_value", got_rdata,        32'h0000_00DE);

        // Misaligned word load at 0x12.
        run_and_check("ld_split", 1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0);
        if (MIS_EN) begin
            check("ld_split_a0",    32'(beat_addr[0]), 32'd4);
            check("ld_split_s0",    32'(beat_sel[0]),  32'hC);
            check("ld_split_a1",    32'(beat_addr[1]), 32'd5);
            check("ld_split_s1",    32'(beat_sel[1]),  32'h3);
            check("ld_split_value", got_rdata,         32'h3344_DEAD);
        end else begin
            check("ld_split_errflag", 32'(got_err), 32'd1);
        end

        // Misaligned half store at 0x17.
        run_and_check("st_half", 1'b1, 2'b01, 1'b0, 32'h0000_0017, 32'h0000_ABCD);
        if (MIS_EN) begin
            check("st_half_a0", 32'(beat_addr[0]),       32'd5);
            check("st_half_s0", 32'(beat_sel[0]),        32'h8);
            check("st_half_d0", 32'(beat_data[0][31:24]), 32'hCD);
            check("st_half_a1", 32'(beat_addr[1]),       32'd6);
            check("st_half_s1", 32'(beat_sel[1]),        32'h1);
            check("st_half_d1", 32'(beat_data[1][7:0]),  32'hAB);
        end

        // Second beat wraps to word 0.
        run_and_check("st_wrap", 1'b1, 2'b10, 1'b0, 32'hFFFF_7FFD, 32'hCAFE_F00D);
        if (MIS_EN) begin
            check("st_wrap_a0", 32'(beat_addr[0]), 32'h1FFF);
            check("st_wrap_a1", 32'(beat_addr[1]), 32'h0000);
        end

        // Reserved size.
        run_and_check("rsvd", 1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0);
        check("rsvd_errflag", 32'(got_err), 32'd1);

        // Reset while the first beat of a store is on the bus.
        @(negedge clk_i);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = 1'b1;
        bus.req_size_i     = 2'b10;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = MIS_EN ? 32'h0000_0021 : 32'h0000_0020;
        bus.req_wdata_i    = 32'h5555_AAAA;
        check("rr_ready_before", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk_i);
        #1 bus.req_valid_i = 1'b0;
        check("rr_in_acc0_bsel", 32'(mem_b_sel_o != 4'b0000), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rr_rst_write", 32'(mem_write_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rr_ready_after", 32'(bus.req_ready_o), 32'd1);
        quiet_valid = 0;
        quiet_write = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            if (bus.rsp_valid_o === 1'b1) quiet_valid++;
            if (mem_write_o === 1'b1) quiet_write++;
        end
        check("rr_no_rsp",   32'(quiet_valid), 32'd0);
        check("rr_no_write", 32'(quiet_write), 32'd0);
        check("rr_word8",  bus_mem[8], {ref_mem[35], ref_mem[34], ref_mem[33], ref_mem[32]});
        check("rr_word9",  bus_mem[9], {ref_mem[39], ref_mem[38], ref_mem[37], ref_mem[36]});

        // Random accesses: a small hot window plus the top of the address space.
        for (int t = 0; t < 80; t++) begin
            logic [31:0] r, a, wd;
            logic [1:0]  sz;
            logic        we, un;
            r  = $urandom();
            wd = $urandom();
            if ($urandom_range(0, 3) == 0) a = {r[31:15], 15'h7FFC + 15'($urandom_range(0, 3))};
            else                           a = {r[31:15], 15'($urandom_range(0, 63))};
            sz = 2'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            un = 1'($urandom_range(0, 1));
            run_and_check("rnd", we, sz, un, a, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port req_valid_i, input, 1, CPU access request.
REQ-004 SHALL have port req_ready_o, output, 1, request accepted when req_valid_i & req_ready_o at a clock edge.
REQ-005 SHALL have port req_we_i, input, 1, 1=store, 0=load.
REQ-006 SHALL have port req_size_i, input, 2, 00=byte, 01=half, 10=word, 11=reserved.
REQ-007 SHALL have port req_unsigned_i, input, 1, load zero-extends (1) or sign-extends (0).
REQ-008 SHALL have port req_addr_i, input, 32, byte address; only bits [14:0] are used.
REQ-009 SHALL have port req_wdata_i, input, 32, store data, right-justified.
REQ-010 SHALL have port rsp_valid_o, output, 1, one-cycle completion pulse; not backpressured.
REQ-011 SHALL have port rsp_rdata_o, output, 32, extended load data; 0 for stores and errors.
REQ-012 SHALL have port rsp_err_o, output, 1, valid with rsp_valid_o.
REQ-013 SHALL have memory-side ports: mem_write_o (out, 1), mem_b_sel_o (out, 4), mem_addr_o (out, 13, word index), mem_data_o (out, 32), and mem_data_i (in, 32, combinational read data; unselected lanes read 0).

Function
REQ-014 SHALL implement FSM states IDLE, ACC0, ACC1, RESP.
REQ-015 SHALL assert req_ready_o only in IDLE and register all request fields on acceptance.
REQ-016 SHALL, on acceptance, go IDLE->ACC0, or IDLE->RESP with error for size 11 or for a misaligned access when misalignment is disabled.
REQ-017 SHALL compute lanes = {0001,0011,1111}[size] << addr[1:0] (8 bits); lanes[3:0] drive beat0, lanes[7:4] drive beat1.
REQ-018 SHALL classify an access as split when lanes[7:4] != 0 (half at offset 3, word at offset 1-3).
REQ-019 SHALL in ACC0 drive mem_addr_o=addr[14:2], mem_b_sel_o=lanes[3:0], and mem_write_o=req_we; it then goes to ACC1 if split, else to RESP.
REQ-020 SHALL in ACC1 drive mem_addr_o=addr[14:2]+1 (13-bit wrap, 0x1FFF->0x0000), mem_b_sel_o=lanes[7:4], and mem_write_o=req_we; it then goes to RESP.
REQ-021 SHALL form store data as the 64-bit value wdata << 8*addr[1:0]; bits [31:0] go to beat0 and [63:32] go to beat1.
REQ-022 SHALL capture mem_data_i at the end of each load beat, then form {beat1,beat0} >> 8*addr[1:0] and truncate/extend it per size and req_unsigned_i.
REQ-023 SHALL in RESP assert rsp_valid_o for exactly one cycle, then return to IDLE.
REQ-024 SHALL latency: accept edge T; aligned rsp_valid_o at cycle T+2; split at T+3; error at T+1.
REQ-025 SHALL drive mem_write_o=0, mem_b_sel_o=0, mem_addr_o=0, and mem_data_o=0 outside ACC0/ACC1.

Reset
REQ-026 SHALL on rst_i force IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, and all mem_* outputs=0; req_ready_o=1 the cycle after rst_i deasserts.
REQ-027 SHALL abandon any in-flight access on rst_i, including mid-split: no further beat is issued and no response is produced.

Configuration
REQ-028 SHALL, with LSU_MISALIGN_EN defined, execute split accesses as two beats per REQ-019..022.
REQ-029 SHALL, without LSU_MISALIGN_EN, answer split accesses with rsp_err_o=1 and no memory beat; ACC1 and the beat1 datapath are removed.

Structure
REQ-030 SHALL place the size encodings and the FSM state enum in shared package lsu_pkg.
REQ-031 SHALL put lane generation, store shifting, and load extraction/extension in combinational sub-module lsu_align.

Verification
REQ-032 SHALL test: word store at 0x10, data 0xDEADBEEF -> ACC0 with mem_addr_o=4, b_sel=1111, mem_write_o=1; rsp_valid_o at T+2 with rdata 0.
REQ-033 SHALL test: with word4=0xDEADBEEF, signed byte load at 0x13 -> b_sel=1000, rdata 0xFFFFFFDE; the unsigned load returns 0x000000DE.
REQ-034 SHALL test: with word4=0xDEADBEEF and word5=0x11223344, word load at 0x12 (macro on) -> beat0 addr 4 b_sel 1100, beat1 addr 5 b_sel 0011, rdata 0x3344DEAD at T+3; with the macro off -> rsp_err_o=1 at T+1 and b_sel stays 0.
REQ-035 SHALL test: half store 0xABCD at 0x17 -> beat0 addr 5 b_sel 1000 with mem_data_o[31:24]=0xCD; beat1 addr 6 b_sel 0001 with mem_data_o[7:0]=0xAB.
REQ-036 SHALL test: size 11 -> rsp_err_o=1 with no beat; rst_i asserted during ACC0 of a split store -> no ACC1 write, no rsp_valid_o, and req_ready_o=1 after reset.
